// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the byte requesters, the arbiter and the shared uart_tx.
// The slave modport is the arbiter's view. The master modport is the view of
// the requesters plus the transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int N       = 8
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ*N-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_ack;
  logic                 o_tx_start;
  logic [N-1:0]         o_tx_data;
  logic                 i_tx_busy;
  logic [OW-1:0]        o_owner;
  logic                 o_active;
  logic                 o_timeout_err;

  modport slave (
    input  i_req, i_req_data, i_tx_busy,
    output o_ack, o_tx_start, o_tx_data, o_owner, o_active, o_timeout_err
  );

  modport master (
    output i_req, i_req_data, i_tx_busy,
    input  o_ack, o_tx_start, o_tx_data, o_owner, o_active, o_timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ byte producers.
// Each requester sees a per-byte req/ack handshake. The arbiter holds
// start_tx until the transmitter reports busy. If busy never shows up, the
// arbiter gives up after BUSY_TIMEOUT cycles and reports the abort.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int N            = 8,
  parameter int BUSY_TIMEOUT = 8192
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(BUSY_TIMEOUT);
  localparam logic [OW-1:0] LAST_INIT = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             r_state, w_stateNext;
  logic [OW-1:0]      r_lastGrant, w_lastGrantNext;
  logic [OW-1:0]      r_owner, w_ownerNext;
  logic [CW-1:0]      r_count, w_countNext;
  logic               r_txStart, w_txStartNext;
  logic [N-1:0]       r_txData, w_txDataNext;
  logic [NUM_REQ-1:0] r_ack, w_ackNext;
  logic               r_timeoutErr, w_timeoutErrNext;
  logic               r_active;

  logic               w_found;
  logic [OW-1:0]      w_winner;
  logic [OW-1:0]      w_cand;

  // Find the first asserted req after the last served requester, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = OW'((int'(r_lastGrant) + k) % NUM_REQ);
      if (!w_found && bus.i_req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Next-state and next-output logic for the IDLE / LAUNCH / WAIT_DONE sequence.
  always_comb begin
    w_stateNext      = r_state;
    w_lastGrantNext  = r_lastGrant;
    w_ownerNext      = r_owner;
    w_countNext      = r_count;
    w_txStartNext    = r_txStart;
    w_txDataNext     = r_txData;
    w_ackNext        = '0;
    w_timeoutErrNext = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found && !bus.i_tx_busy) begin
          w_ownerNext   = w_winner;
          w_txDataNext  = bus.i_req_data[int'(w_winner)*N +: N];
          w_txStartNext = 1'b1;
          w_countNext   = '0;
          w_stateNext   = LAUNCH;
        end
      end
      LAUNCH: begin
        if (r_count != CNT_MAX) begin
          w_countNext = r_count + 1'b1;
        end
        if (bus.i_tx_busy) begin
          w_txStartNext      = 1'b0;
          w_ackNext[r_owner] = 1'b1;
          w_stateNext        = WAIT_DONE;
        end else if (r_count == CNT_LAST) begin
          w_txStartNext    = 1'b0;
          w_timeoutErrNext = 1'b1;
          w_lastGrantNext  = r_owner;
          w_stateNext      = IDLE;
        end
      end
      WAIT_DONE: begin
        w_txStartNext = 1'b0;
        if (!bus.i_tx_busy) begin
          w_lastGrantNext = r_owner;
          w_stateNext     = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Register the state and all outputs; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lastGrant  <= LAST_INIT;
      r_owner      <= '0;
      r_count      <= '0;
      r_txStart    <= 1'b0;
      r_txData     <= '0;
      r_ack        <= '0;
      r_timeoutErr <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_lastGrant  <= w_lastGrantNext;
      r_owner      <= w_ownerNext;
      r_count      <= w_countNext;
      r_txStart    <= w_txStartNext;
      r_txData     <= w_txDataNext;
      r_ack        <= w_ackNext;
      r_timeoutErr <= w_timeoutErrNext;
      r_active     <= (w_stateNext != IDLE);
    end
  end

  assign bus.o_ack         = r_ack;
  assign bus.o_tx_start    = r_txStart;
  assign bus.o_tx_data     = r_txData;
  assign bus.o_owner       = r_owner;
  assign bus.o_active      = r_active;
  assign bus.o_timeout_err = r_timeoutErr;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a reactive requester/transmitter
// environment and a per-byte reference model of the arbitration rules.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int N            = 8;
  localparam int BUSY_TIMEOUT = 16;
  localparam int PH_IDLE      = 0;
  localparam int PH_LAUNCH    = 1;
  localparam int PH_DRAIN     = 2;

  logic clk = 1'b0;
  logic reset;

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .N(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .N(N),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int compareCount = 0;
  int mismatchCount = 0;

  logic                 drvReset;
  logic [NUM_REQ-1:0]   drvReq;
  logic [NUM_REQ*N-1:0] drvData;
  logic                 drvBusy;
  bit keepReq, randomMode, forceBusy, txNever, txArmed;
  int riseDelay, frameLen, riseLeft, busyLeft;

  int mPhase, mLast, mLaunchCycles;
  logic               expStart;
  logic [N-1:0]       expData;
  int                 expOwner;
  logic [NUM_REQ-1:0] expAck;
  logic               expActive, expTimeout;

  int grantLog[$];
  int dataLog[$];
  int ackPer[NUM_REQ];
  int ackCount, timeoutCount, startHighCount, startAtTimeout, ackAtTimeout, firstAck;
  logic prevStart;

  // Compare one observed value against its expected value and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Round-robin pick: first asserted request after 'last', wrapping around.
  function automatic int rrPick(input int last, input logic [NUM_REQ-1:0] req);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (req[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int qAt(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  // Reference model: advance one clock using the inputs the DUT just sampled.
  task automatic modelStep(input logic rst, input logic [NUM_REQ-1:0] req,
                           input logic [NUM_REQ*N-1:0] data, input logic busy);
    int w;
    expAck     = '0;
    expTimeout = 1'b0;
    if (rst) begin
      expStart = 1'b0; expData = '0; expOwner = 0;
      mLast = NUM_REQ - 1; mPhase = PH_IDLE; mLaunchCycles = 0;
    end else begin
      case (mPhase)
        PH_IDLE: begin
          if (req != '0 && !busy) begin
            w = rrPick(mLast, req);
            expOwner = w;
            expData  = data[w*N +: N];
            expStart = 1'b1;
            mLaunchCycles = 0;
            mPhase = PH_LAUNCH;
          end
        end
        PH_LAUNCH: begin
          mLaunchCycles++;
          if (busy) begin
            expStart = 1'b0;
            expAck[expOwner] = 1'b1;
            mPhase = PH_DRAIN;
          end else if (mLaunchCycles == BUSY_TIMEOUT) begin
            expStart = 1'b0;
            expTimeout = 1'b1;
            mLast = expOwner;
            mPhase = PH_IDLE;
          end
        end
        default: begin
          if (!busy) begin
            mLast = expOwner;
            mPhase = PH_IDLE;
          end
        end
      endcase
    end
    expActive = (mPhase != PH_IDLE);
  endtask

  task automatic clearLogs();
    grantLog.delete();
    dataLog.delete();
    for (int i = 0; i < NUM_REQ; i++) ackPer[i] = 0;
    ackCount = 0; timeoutCount = 0; startHighCount = 0;
    startAtTimeout = -1; ackAtTimeout = -1; firstAck = 0;
  endtask

  // One clock: drive inputs, step the model, check outputs, then react like requesters and uart_tx.
  task automatic applyStimulus();
    reset = drvReset;
    bus.i_req = drvReq;
    bus.i_req_data = drvData;
    bus.i_tx_busy = drvBusy;
    @(posedge clk);
    modelStep(drvReset, drvReq, drvData, drvBusy);
    @(negedge clk);
    checkOutput("tx_start", 32'(bus.o_tx_start), 32'(expStart));
    checkOutput("tx_data", 32'(bus.o_tx_data), 32'(expData));
    checkOutput("owner", 32'(bus.o_owner), 32'(expOwner));
    checkOutput("ack", 32'(bus.o_ack), 32'(expAck));
    checkOutput("active", 32'(bus.o_active), 32'(expActive));
    checkOutput("timeout_err", 32'(bus.o_timeout_err), 32'(expTimeout));

    if (bus.o_tx_start) startHighCount++;
    if (bus.o_tx_start && !prevStart) begin
      grantLog.push_back(int'(bus.o_owner));
      dataLog.push_back(int'(bus.o_tx_data));
      if (randomMode) begin
        txNever   = ($urandom_range(0, 9) == 0);
        riseDelay = $urandom_range(1, 6);
        frameLen  = $urandom_range(2, 8);
      end
    end
    if (bus.o_ack != '0 && firstAck == 0) firstAck = int'(bus.o_ack);
    if (bus.o_timeout_err) begin
      if (timeoutCount == 0) begin
        startAtTimeout = startHighCount;
        ackAtTimeout   = ackCount;
      end
      timeoutCount++;
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.o_ack[i]) begin
        ackCount++;
        ackPer[i]++;
        if (randomMode) begin
          if ($urandom_range(0, 1) == 1) drvData[i*N +: N] = 8'($urandom);
          else drvReq[i] = 1'b0;
        end else if (!keepReq) begin
          drvReq[i] = 1'b0;
        end
      end else if (randomMode && !drvReq[i] && $urandom_range(0, 3) == 0) begin
        drvReq[i] = 1'b1;
        drvData[i*N +: N] = 8'($urandom);
      end
    end

    if (!forceBusy) begin
      if (drvBusy) begin
        busyLeft--;
        if (busyLeft <= 0) drvBusy = 1'b0;
      end else if (txArmed) begin
        riseLeft--;
        if (riseLeft <= 0) begin
          drvBusy = 1'b1;
          busyLeft = frameLen;
          txArmed = 1'b0;
        end
      end else if (bus.o_tx_start && !txNever) begin
        txArmed = 1'b1;
        riseLeft = riseDelay;
      end
    end
    prevStart = bus.o_tx_start;
    if (randomMode) drvReset = ($urandom_range(0, 399) == 0);
  endtask

  task automatic startTest();
    drvReset = 1'b1; drvReq = '0; drvBusy = 1'b0;
    txArmed = 1'b0; busyLeft = 0; txNever = 1'b0;
    forceBusy = 1'b0; randomMode = 1'b0; keepReq = 1'b0;
    applyStimulus();
    applyStimulus();
    drvReset = 1'b0;
    clearLogs();
  endtask

  // Safety net in case a wait loop is ever broken.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drvReset = 1'b1; drvReq = '0; drvData = '0; drvBusy = 1'b0;
    keepReq = 0; randomMode = 0; forceBusy = 0; txNever = 0; txArmed = 0;
    riseDelay = 2; frameLen = 3; riseLeft = 0; busyLeft = 0;
    mPhase = PH_IDLE; mLast = NUM_REQ - 1; mLaunchCycles = 0;
    expStart = 0; expData = '0; expOwner = 0; expAck = '0; expActive = 0; expTimeout = 0;
    prevStart = 1'b0;
    reset = 1'b1; bus.i_req = '0; bus.i_req_data = '0; bus.i_tx_busy = 1'b0;
    clearLogs();
    @(negedge clk);

    $display("[TB] reset values");
    startTest();
    checkOutput("reset_tx_start", 32'(bus.o_tx_start), 32'd0);
    checkOutput("reset_owner", 32'(bus.o_owner), 32'd0);
    checkOutput("reset_active", 32'(bus.o_active), 32'd0);
    checkOutput("reset_ack", 32'(bus.o_ack), 32'd0);

    $display("[TB] single requester");
    startTest();
    riseDelay = 3; frameLen = 5;
    drvData[0 +: N] = 8'hA5;
    drvReq = 4'b0001;
    for (int c = 0; c < 80 && !(ackCount >= 1 && !bus.o_active); c++) applyStimulus();
    checkOutput("single_done", 32'(ackCount >= 1 && !bus.o_active), 32'd1);
    checkOutput("single_start_cycles", 32'(startHighCount), 32'd4);
    checkOutput("single_data", 32'(qAt(dataLog, 0)), 32'hA5);
    checkOutput("single_owner", 32'(qAt(grantLog, 0)), 32'd0);
    checkOutput("single_ack_mask", 32'(firstAck), 32'b0001);
    checkOutput("single_ack_count", 32'(ackCount), 32'd1);

    $display("[TB] round robin");
    startTest();
    riseDelay = 2; frameLen = 3; keepReq = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) drvData[i*N +: N] = 8'(8'h10 + i);
    drvReq = 4'b1111;
    for (int c = 0; c < 300 && grantLog.size() < 5; c++) applyStimulus();
    checkOutput("rr_grants", 32'(grantLog.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++) checkOutput("rr_byte", 32'(qAt(dataLog, k)), 32'(8'h10 + (k % NUM_REQ)));
    for (int i = 0; i < NUM_REQ; i++) checkOutput("rr_acks_per_req", 32'(ackPer[i]), 32'd1);
    keepReq = 1'b0;
    drvReq = '0;
    for (int c = 0; c < 60 && bus.o_active; c++) applyStimulus();

    $display("[TB] fairness after partial round");
    startTest();
    riseDelay = 2; frameLen = 3;
    for (int i = 0; i < NUM_REQ; i++) drvData[i*N +: N] = 8'(8'h20 + i);
    drvReq = 4'b0010;
    for (int c = 0; c < 60 && !(ackCount >= 1 && !bus.o_active); c++) applyStimulus();
    drvReq = 4'b0101;
    for (int c = 0; c < 200 && !(ackCount >= 3 && !bus.o_active); c++) applyStimulus();
    checkOutput("fair_done", 32'(ackCount >= 3 && !bus.o_active), 32'd1);
    checkOutput("fair_first", 32'(qAt(grantLog, 0)), 32'd1);
    checkOutput("fair_second", 32'(qAt(grantLog, 1)), 32'd2);
    checkOutput("fair_third", 32'(qAt(grantLog, 2)), 32'd0);

    $display("[TB] launch timeout");
    startTest();
    riseDelay = 2; frameLen = 3; txNever = 1'b1;
    drvReq = 4'b0010;
    for (int c = 0; c < 10 && grantLog.size() < 1; c++) applyStimulus();
    drvReq = 4'b1011;
    for (int c = 0; c < 40 && timeoutCount < 1; c++) applyStimulus();
    checkOutput("to_seen", 32'(timeoutCount), 32'd1);
    checkOutput("to_start_cycles", 32'(startAtTimeout), 32'(BUSY_TIMEOUT));
    checkOutput("to_no_ack", 32'(ackAtTimeout), 32'd0);
    txNever = 1'b0;
    for (int c = 0; c < 200 && !(ackCount >= 3 && !bus.o_active); c++) applyStimulus();
    checkOutput("to_done", 32'(ackCount >= 3 && !bus.o_active), 32'd1);
    checkOutput("to_grant1", 32'(qAt(grantLog, 1)), 32'd3);
    checkOutput("to_grant2", 32'(qAt(grantLog, 2)), 32'd0);
    checkOutput("to_grant3", 32'(qAt(grantLog, 3)), 32'd1);

    $display("[TB] busy at reset");
    startTest();
    forceBusy = 1'b1; drvBusy = 1'b1;
    drvData[0 +: N] = 8'h3C;
    drvReset = 1'b1; drvReq = 4'b0001;
    applyStimulus();
    drvReset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus();
      checkOutput("busyrst_hold", 32'(bus.o_tx_start), 32'd0);
    end
    drvBusy = 1'b0;
    for (int c = 0; c < 4 && !bus.o_tx_start; c++) applyStimulus();
    checkOutput("busyrst_launch", 32'(bus.o_tx_start), 32'd1);
    checkOutput("busyrst_data", 32'(bus.o_tx_data), 32'h3C);
    forceBusy = 1'b0; riseDelay = 2; frameLen = 3;
    for (int c = 0; c < 60 && !(ackCount >= 1 && !bus.o_active); c++) applyStimulus();
    checkOutput("busyrst_done", 32'(ackCount >= 1 && !bus.o_active), 32'd1);

    $display("[TB] reset during launch");
    startTest();
    txNever = 1'b1;
    drvReq = 4'b0100;
    for (int c = 0; c < 10 && grantLog.size() < 1; c++) applyStimulus();
    for (int c = 0; c < 3; c++) applyStimulus();
    checkOutput("midrst_launching", 32'(bus.o_tx_start), 32'd1);
    drvReset = 1'b1; drvReq = 4'b1111;
    applyStimulus();
    checkOutput("midrst_tx_start", 32'(bus.o_tx_start), 32'd0);
    checkOutput("midrst_active", 32'(bus.o_active), 32'd0);
    checkOutput("midrst_ack", 32'(bus.o_ack), 32'd0);
    checkOutput("midrst_owner", 32'(bus.o_owner), 32'd0);
    drvReset = 1'b0; txNever = 1'b0; riseDelay = 2; frameLen = 3;
    clearLogs();
    for (int c = 0; c < 10 && grantLog.size() < 1; c++) applyStimulus();
    checkOutput("midrst_first_grant", 32'(qAt(grantLog, 0)), 32'd0);
    for (int c = 0; c < 300 && !(ackCount >= 4 && !bus.o_active); c++) applyStimulus();
    checkOutput("midrst_all_served", 32'(ackCount >= 4 && !bus.o_active), 32'd1);

    $display("[TB] randomized traffic");
    startTest();
    randomMode = 1'b1;
    for (int c = 0; c < 3000; c++) applyStimulus();
    randomMode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule
